// File: rtl/sext_pkg.sv
// Shared constants for the sign-extension arbiter: widths, requester IDs and
// output-register controller states.
package sext_pkg;

  localparam int WORD_W = 32;
  localparam int POS_W  = 5;

  localparam logic REQ_DEC = 1'b0;
  localparam logic REQ_EXE = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage : sext_pkg

// File: rtl/sign_extend_32.sv
// Combinational sign extension with big-endian bit numbering (bit 0 = MSB):
// every bit above the sign position is replaced by a[pos].
module sign_extend_32
  import sext_pkg::*;
(
  input  logic [0:WORD_W-1] a,
  input  logic [0:POS_W-1]  pos,
  output logic [0:WORD_W-1] y
);

  logic sign_bit;

  assign sign_bit = a[pos];

  always_comb begin
    for (int i = 0; i < WORD_W; i++) begin
      y[i] = (i < int'(pos)) ? sign_bit : a[i];
    end
  end

endmodule : sign_extend_32

// File: rtl/sext_arbiter.sv
// Round-robin arbiter sharing one sign-extension unit between the decode and
// execute requesters, with a one-entry result register per accepted request.
module sext_arbiter
  import sext_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_0,
  input  logic              req_valid_1,
  output logic              req_ready_0,
  output logic              req_ready_1,
  input  logic [0:WORD_W-1] req_a_0,
  input  logic [0:WORD_W-1] req_a_1,
  input  logic [0:POS_W-1]  req_pos_0,
  input  logic [0:POS_W-1]  req_pos_1,
  output logic              rsp_valid_0,
  output logic              rsp_valid_1,
  input  logic              rsp_ready_0,
  input  logic              rsp_ready_1,
  output logic [0:WORD_W-1] rsp_y
);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              prio_q, prio_d;
  logic [0:WORD_W-1] y_q, y_d;

  logic              full;
  logic              drain;
  logic              free;
  logic              winner;
  logic              accept;
  logic [0:WORD_W-1] sel_a;
  logic [0:POS_W-1]  sel_pos;
  logic [0:WORD_W-1] ext_y;

  assign full  = (state_q == ST_FULL);
  assign drain = full & ((owner_q == REQ_EXE) ? rsp_ready_1 : rsp_ready_0);
  assign free  = ~full | drain;

  // Contention goes to prio; otherwise whichever single requester is valid.
  assign winner = (req_valid_0 & req_valid_1) ? prio_q :
                  (req_valid_1 ? REQ_EXE : REQ_DEC);
  assign accept = (req_valid_0 | req_valid_1) & free & ~rst;

  assign req_ready_0 = accept & (winner == REQ_DEC);
  assign req_ready_1 = accept & (winner == REQ_EXE);

  assign sel_a   = (winner == REQ_EXE) ? req_a_1 : req_a_0;
  assign sel_pos = (winner == REQ_EXE) ? req_pos_1 : req_pos_0;

  sign_extend_32 u_sext (
    .a   (sel_a),
    .pos (sel_pos),
    .y   (ext_y)
  );

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    y_d     = y_q;
    unique case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (drain && !accept) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
    if (accept) begin
      owner_d = winner;
      prio_d  = ~winner;
      y_d     = ext_y;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      owner_q <= REQ_DEC;
      prio_q  <= REQ_DEC;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      y_q     <= y_d;
    end
  end

  assign rsp_valid_0 = full & (owner_q == REQ_DEC);
  assign rsp_valid_1 = full & (owner_q == REQ_EXE);
  assign rsp_y       = y_q;

endmodule : sext_arbiter

// File: tb/tb_sext_arbiter.sv
// Directed self-checking bench for sext_arbiter: latency, extension results,
// round-robin order, backpressure, ignored ready and mid-operation reset.
module tb_sext_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_0, req_valid_1;
  logic        req_ready_0, req_ready_1;
  logic [0:31] req_a_0, req_a_1;
  logic [0:4]  req_pos_0, req_pos_1;
  logic        rsp_valid_0, rsp_valid_1;
  logic        rsp_ready_0, rsp_ready_1;
  logic [0:31] rsp_y;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sext_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_0 (req_valid_0),
    .req_valid_1 (req_valid_1),
    .req_ready_0 (req_ready_0),
    .req_ready_1 (req_ready_1),
    .req_a_0     (req_a_0),
    .req_a_1     (req_a_1),
    .req_pos_0   (req_pos_0),
    .req_pos_1   (req_pos_1),
    .rsp_valid_0 (rsp_valid_0),
    .rsp_valid_1 (rsp_valid_1),
    .rsp_ready_0 (rsp_ready_0),
    .rsp_ready_1 (rsp_ready_1),
    .rsp_y       (rsp_y)
  );

  // Advance one clock; inputs are then driven and outputs sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid_0 = 1'b1; req_valid_1 = 1'b0;
    req_a_0 = 32'h0000_00FF; req_pos_0 = 5'd24;
    req_a_1 = '0; req_pos_1 = '0;
    rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;
    tick();
    tick();
    checks++; if (req_ready_0 !== 1'b0) begin errors++; $display("FAIL reset_req_ready_0: got %b want 0", req_ready_0); end
    checks++; if (rsp_valid_0 !== 1'b0 || rsp_valid_1 !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b%b want 00", rsp_valid_0, rsp_valid_1); end
    checks++; if (rsp_y !== 32'h0) begin errors++; $display("FAIL reset_rsp_y: got %h want 00000000", rsp_y); end
    rst = 1'b0;
    req_valid_0 = 1'b0;
    tick();
    checks++; if (rsp_valid_0 !== 1'b0) begin errors++; $display("FAIL reset_no_accept: got %b want 0", rsp_valid_0); end
  endtask

  task automatic test_latency();
    req_valid_0 = 1'b1; req_a_0 = 32'h0000_00FF; req_pos_0 = 5'd24;
    #1;
    checks++; if (req_ready_0 !== 1'b1) begin errors++; $display("FAIL lat_grant: got %b want 1", req_ready_0); end
    tick();
    req_valid_0 = 1'b0;
    checks++; if (rsp_valid_0 !== 1'b1 || rsp_valid_1 !== 1'b0) begin errors++; $display("FAIL lat_valid: got %b%b want 10", rsp_valid_0, rsp_valid_1); end
    checks++; if (rsp_y !== 32'hFFFF_FFFF) begin errors++; $display("FAIL lat_y_pos24: got %h want ffffffff", rsp_y); end
    // Drain and accept in the same cycle: no bubble.
    rsp_ready_0 = 1'b1;
    req_valid_0 = 1'b1; req_pos_0 = 5'd0;
    #1;
    checks++; if (req_ready_0 !== 1'b1) begin errors++; $display("FAIL lat_grant_drain: got %b want 1", req_ready_0); end
    tick();
    req_valid_0 = 1'b0;
    checks++; if (rsp_valid_0 !== 1'b1 || rsp_y !== 32'h0000_00FF) begin errors++; $display("FAIL lat_y_pos0: got v=%b y=%h want v=1 y=000000ff", rsp_valid_0, rsp_y); end
    tick();
    rsp_ready_0 = 1'b0;
    checks++; if (rsp_valid_0 !== 1'b0) begin errors++; $display("FAIL lat_drained: got %b want 0", rsp_valid_0); end
  endtask

  task automatic test_positive();
    req_valid_1 = 1'b1; req_a_1 = 32'h1234_5678; req_pos_1 = 5'd16;
    rsp_ready_1 = 1'b1;
    #1;
    checks++; if (req_ready_1 !== 1'b1 || req_ready_0 !== 1'b0) begin errors++; $display("FAIL pos_grant: got %b%b want 01", req_ready_0, req_ready_1); end
    tick();
    req_valid_1 = 1'b0;
    checks++; if (rsp_valid_1 !== 1'b1 || rsp_valid_0 !== 1'b0) begin errors++; $display("FAIL pos_valid: got %b%b want 01", rsp_valid_0, rsp_valid_1); end
    checks++; if (rsp_y !== 32'h0000_5678) begin errors++; $display("FAIL pos_y: got %h want 00005678", rsp_y); end
    tick();
    rsp_ready_1 = 1'b0;
    checks++; if (rsp_valid_1 !== 1'b0 || rsp_valid_0 !== 1'b0) begin errors++; $display("FAIL pos_drained: got %b%b want 00", rsp_valid_0, rsp_valid_1); end
  endtask

  task automatic test_round_robin();
    logic [0:31] exp_y [2];
    logic        exp_g;
    exp_y[0] = 32'h8000_0000;
    exp_y[1] = 32'hFFFF_8000;
    req_valid_0 = 1'b1; req_a_0 = 32'h8000_0000; req_pos_0 = 5'd0;
    req_valid_1 = 1'b1; req_a_1 = 32'h0000_8000; req_pos_1 = 5'd16;
    rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_g = k[0];
      #1;
      checks++; if (req_ready_0 !== ~exp_g || req_ready_1 !== exp_g) begin errors++; $display("FAIL rr_grant%0d: got %b%b want grant %0d", k, req_ready_0, req_ready_1, exp_g); end
      tick();
      checks++; if (rsp_valid_0 !== ~exp_g || rsp_valid_1 !== exp_g || rsp_y !== exp_y[exp_g]) begin errors++; $display("FAIL rr_rsp%0d: got v=%b%b y=%h want owner %0d y=%h", k, rsp_valid_0, rsp_valid_1, rsp_y, exp_g, exp_y[exp_g]); end
    end
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    tick();
    rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;
  endtask

  // Also covers the non-owner's rsp_ready being ignored.
  task automatic test_backpressure();
    req_valid_0 = 1'b1; req_a_0 = 32'h00F0_0000; req_pos_0 = 5'd8;
    tick();
    req_valid_0 = 1'b0;
    req_valid_1 = 1'b1; req_a_1 = 32'h0000_007F; req_pos_1 = 5'd24;
    rsp_ready_1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (req_ready_1 !== 1'b0 || rsp_valid_0 !== 1'b1) begin errors++; $display("FAIL bp_hold%0d: got rdy1=%b v0=%b want 0 1", k, req_ready_1, rsp_valid_0); end
      checks++; if (rsp_y !== 32'hFFF0_0000) begin errors++; $display("FAIL bp_y%0d: got %h want fff00000", k, rsp_y); end
      tick();
    end
    rsp_ready_0 = 1'b1;
    #1;
    checks++; if (req_ready_1 !== 1'b1) begin errors++; $display("FAIL bp_release: got %b want 1", req_ready_1); end
    tick();
    req_valid_1 = 1'b0; rsp_ready_0 = 1'b0;
    checks++; if (rsp_valid_1 !== 1'b1 || rsp_valid_0 !== 1'b0 || rsp_y !== 32'h0000_007F) begin errors++; $display("FAIL bp_rsp1: got v=%b%b y=%h want 01 0000007f", rsp_valid_0, rsp_valid_1, rsp_y); end
    tick();
    rsp_ready_1 = 1'b0;
  endtask

  task automatic test_reset_mid();
    req_valid_0 = 1'b1; req_a_0 = 32'h0000_00FF; req_pos_0 = 5'd24;
    tick();
    req_valid_0 = 1'b0;
    checks++; if (rsp_valid_0 !== 1'b1) begin errors++; $display("FAIL mid_full: got %b want 1", rsp_valid_0); end
    rst = 1'b1;
    req_valid_0 = 1'b1; req_a_0 = 32'h0000_0080; req_pos_0 = 5'd24;
    req_valid_1 = 1'b1; req_a_1 = 32'h0000_0001; req_pos_1 = 5'd0;
    #1;
    checks++; if (req_ready_0 !== 1'b0 || req_ready_1 !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b%b want 00", req_ready_0, req_ready_1); end
    tick();
    rst = 1'b0;
    checks++; if (rsp_valid_0 !== 1'b0 || rsp_valid_1 !== 1'b0 || rsp_y !== 32'h0) begin errors++; $display("FAIL mid_cleared: got v=%b%b y=%h want 00 00000000", rsp_valid_0, rsp_valid_1, rsp_y); end
    #1;
    checks++; if (req_ready_0 !== 1'b1 || req_ready_1 !== 1'b0) begin errors++; $display("FAIL mid_prio: got %b%b want 10", req_ready_0, req_ready_1); end
    tick();
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    checks++; if (rsp_valid_0 !== 1'b1 || rsp_y !== 32'hFFFF_FF80) begin errors++; $display("FAIL mid_rsp: got v=%b y=%h want 1 ffffff80", rsp_valid_0, rsp_y); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_positive();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_sext_arbiter
